// File: rtl/clk_dds_pkg.sv
// Shared types and constants for the DDS increment slewer.
// Holds the slew state encoding and the bounded step-toward-target helper.
package clk_dds_pkg;

  localparam int INC_W = 32;
  localparam logic [INC_W-1:0] DEFAULT_INCREMENT = 32'h33333333;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DWELL,
    FAULT
  } slew_state_t;

  // Moves cur toward tgt by at most step; step == 0 means jump straight to tgt.
  // Clamping to tgt when the remaining gap is smaller makes overshoot and wrap impossible.
  function automatic logic [INC_W-1:0] step_toward(
    input logic [INC_W-1:0] cur,
    input logic [INC_W-1:0] tgt,
    input logic [INC_W-1:0] step
  );
    logic             up;
    logic [INC_W-1:0] gap;
    up  = (tgt > cur);
    gap = up ? (tgt - cur) : (cur - tgt);
    if ((step == '0) || (step >= gap)) begin
      return tgt;
    end
    return up ? (cur + step) : (cur - step);
  endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that times the dwell between increment steps.
// Load has priority over decrement; the count stops at zero.
module dds_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk_ref,
  input  logic               reset_in,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_ref) begin
    if (reset_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dds_increment_slewer.sv
// Ramps the DDS phase increment toward a programmed target in bounded, dwell-spaced steps.
// Define DDS_SLEW_LOCK_CHECK_EN to freeze the ramp and flag a sticky fault on MMCM lock loss.
module dds_increment_slewer
  import clk_dds_pkg::*;
#(
  parameter logic [31:0] INIT_INCREMENT = DEFAULT_INCREMENT,
  parameter int          DWELL_W        = 16
) (
  input  logic               clk_ref,
  input  logic               reset_in,
  input  logic               go,
  input  logic               abort,
  input  logic [INC_W-1:0]   target_inc,
  input  logic [INC_W-1:0]   step_size,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic               pll_locked,
  output logic [INC_W-1:0]   increment,
  output logic               busy,
  output logic               done,
  output logic               fault
);

  slew_state_t        state_q, state_d;
  logic [INC_W-1:0]   inc_q, inc_d;
  logic [INC_W-1:0]   target_q, target_d;
  logic [INC_W-1:0]   step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               done_q, done_d;
  logic [INC_W-1:0]   next_val;
  logic [DWELL_W-1:0] dwell_reload;
  logic               tmr_load;
  logic               tmr_dec;
  logic               tmr_zero;
  logic               unused_pll_locked;

`ifdef DDS_SLEW_LOCK_CHECK_EN
  logic fault_q, fault_d;
`endif

  assign unused_pll_locked = pll_locked;
  assign next_val = step_toward(inc_q, target_q, step_q);

  // The STEP edge itself is one cycle of the cadence, so the timer runs dwell-1
  // cycles; a zero dwell still yields a change every other cycle.
  assign dwell_reload = (dwell_q == '0) ? '0 : (dwell_q - {{(DWELL_W-1){1'b0}}, 1'b1});

  dds_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk_ref    (clk_ref),
    .reset_in   (reset_in),
    .load_i     (tmr_load),
    .load_val_i (dwell_reload),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    inc_d    = inc_q;
    target_d = target_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
`ifdef DDS_SLEW_LOCK_CHECK_EN
    fault_d  = fault_q;
`endif
    if (abort) begin
      state_d = IDLE;
    end else if (go) begin
      target_d = target_inc;
      step_d   = step_size;
      dwell_d  = dwell_cycles;
      state_d  = STEP;
`ifdef DDS_SLEW_LOCK_CHECK_EN
      fault_d  = 1'b0;
    end else if (((state_q == STEP) || (state_q == DWELL)) && !pll_locked) begin
      state_d = FAULT;
      fault_d = 1'b1;
`endif
    end else begin
      case (state_q)
        STEP: begin
          inc_d = next_val;
          if (next_val == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = DWELL;
            tmr_load = 1'b1;
          end
        end
        DWELL: begin
          if (tmr_zero) begin
            state_d = STEP;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_ref) begin
    if (reset_in) begin
      state_q  <= IDLE;
      inc_q    <= INIT_INCREMENT;
      target_q <= INIT_INCREMENT;
      step_q   <= '0;
      dwell_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      inc_q    <= inc_d;
      target_q <= target_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      done_q   <= done_d;
    end
  end

`ifdef DDS_SLEW_LOCK_CHECK_EN
  always_ff @(posedge clk_ref) begin
    if (reset_in) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign increment = inc_q;
  // Busy covers the done cycle so the pulse is never seen while already idle.
  assign busy      = (state_q != IDLE) || done_q;
  assign done      = done_q;

endmodule
